// File: rtl/arb_grant_monitor.sv
// arb_grant_monitor: passive monitor beside the multi-mode arbiter; counts grants, tracks worst-case
// wait, flags starvation and grant-protocol errors, APB readable. Define ARB_MON_IRQ_EN for IRQ/IRQ_MASK.
module arb_grant_monitor #(
  parameter int         N_REQ            = 4,
  parameter logic [7:0] STARVE_LIMIT_RST = 8'd16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [7:0]       PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PWDATA,
  output logic [7:0]       PRDATA,
  output logic             PREADY,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] GNT,
  output logic [N_REQ-1:0] STARVE,
  output logic             IRQ
);

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_LIMIT    = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h08;
  localparam logic [7:0] ADDR_IRQ_MASK = 8'h0C;
  localparam logic [7:0] ADDR_GNT_CNT  = 8'h10;
  localparam logic [7:0] ADDR_MAX_WAIT = 8'h20;
  localparam logic [N_REQ-1:0] ONE_HOT0 = 1;

  logic             en;
  logic [7:0]       starve_limit;
  logic [N_REQ-1:0] starve_flags;
  logic             multi_err;
  logic             spur_err;
  logic [7:0]       status_byte;
  logic [7:0]       rdata;

  logic [7:0]       wait_cnt  [N_REQ];
  logic [7:0]       wait_next [N_REQ];
  logic [7:0]       max_wait  [N_REQ];
  logic [7:0]       gnt_cnt   [N_REQ];
  logic [N_REQ-1:0] gnt_prev;

  logic             wr_en;
  logic             wr_ctrl;
  logic             wr_limit;
  logic             wr_status;
  logic             clr;
  logic [N_REQ-1:0] wait_inc;
  logic [N_REQ-1:0] gnt_edge;
  logic [N_REQ-1:0] starve_set;
  logic [N_REQ-1:0] starve_w1c;
  logic             multi_set;
  logic             spur_set;

`ifdef ARB_MON_IRQ_EN
  logic [5:0] irq_mask;
  logic       irq_q;
  logic       wr_irq_mask;
`endif

  assign PREADY    = 1'b1;
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign wr_ctrl   = wr_en && (PADDR == ADDR_CTRL);
  assign wr_limit  = wr_en && (PADDR == ADDR_LIMIT);
  assign wr_status = wr_en && (PADDR == ADDR_STATUS);
  // CLR is never stored; it acts only on the edge that commits the write.
  assign clr       = wr_ctrl & PWDATA[1];

  assign multi_set = en & (|(GNT & (GNT - ONE_HOT0)));
  assign spur_set  = en & (|(GNT & ~REQ));

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wait_inc[i]   = en & REQ[i] & ~GNT[i];
      wait_next[i]  = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
      gnt_edge[i]   = en & GNT[i] & ~gnt_prev[i];
      // Fires only on the step that lands exactly on the limit, so a saturated counter sets it once.
      starve_set[i] = wait_inc[i] && (starve_limit != 8'h00) &&
                      (wait_next[i] == starve_limit) && (wait_cnt[i] != starve_limit);
      starve_w1c[i] = wr_status & PWDATA[i];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en           <= 1'b1;
      starve_limit <= STARVE_LIMIT_RST;
    end else begin
      if (wr_ctrl) en <= PWDATA[0];
      if (wr_limit) starve_limit <= PWDATA;
    end
  end

  // Hardware set is OR-ed in after the W1C mask so a coincident set survives the clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      starve_flags <= '0;
      multi_err    <= 1'b0;
      spur_err     <= 1'b0;
    end else if (clr) begin
      starve_flags <= '0;
      multi_err    <= 1'b0;
      spur_err     <= 1'b0;
    end else begin
      starve_flags <= (starve_flags & ~starve_w1c) | starve_set;
      multi_err    <= (multi_err & ~(wr_status & PWDATA[4])) | multi_set;
      spur_err     <= (spur_err  & ~(wr_status & PWDATA[5])) | spur_set;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= 8'h00;
        max_wait[i] <= 8'h00;
        gnt_cnt[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (clr) begin
          wait_cnt[i] <= 8'h00;
          max_wait[i] <= 8'h00;
          gnt_cnt[i]  <= 8'h00;
        end else begin
          wait_cnt[i] <= wait_inc[i] ? wait_next[i] : 8'h00;
          if (wait_inc[i] && (wait_next[i] > max_wait[i])) max_wait[i] <= wait_next[i];
          if (gnt_edge[i] && (gnt_cnt[i] != 8'hFF)) gnt_cnt[i] <= gnt_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Tracks GNT regardless of EN or CLR so re-enabling never sees a stale edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) gnt_prev <= '0;
    else          gnt_prev <= GNT;
  end

  always_comb begin
    status_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) status_byte[i] = starve_flags[i];
    status_byte[4] = multi_err;
    status_byte[5] = spur_err;
  end

  always_comb begin
    rdata = 8'h00;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_CTRL:     rdata = {7'b0000000, en};
        ADDR_LIMIT:    rdata = starve_limit;
        ADDR_STATUS:   rdata = status_byte;
`ifdef ARB_MON_IRQ_EN
        ADDR_IRQ_MASK: rdata = {2'b00, irq_mask};
`endif
        default:       rdata = 8'h00;
      endcase
      for (int i = 0; i < N_REQ; i++) begin
        if (PADDR == 8'(ADDR_GNT_CNT + i))  rdata = gnt_cnt[i];
        if (PADDR == 8'(ADDR_MAX_WAIT + i)) rdata = max_wait[i];
      end
    end
  end

  assign PRDATA = rdata;
  assign STARVE = starve_flags;

`ifdef ARB_MON_IRQ_EN
  assign wr_irq_mask = wr_en && (PADDR == ADDR_IRQ_MASK);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_mask <= 6'h00;
      irq_q    <= 1'b0;
    end else begin
      if (wr_irq_mask) irq_mask <= PWDATA[5:0];
      irq_q <= |(status_byte[5:0] & irq_mask);
    end
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_arb_grant_monitor.sv
// tb_arb_grant_monitor: scoreboard bench for arb_grant_monitor; APB read expectations are queued
// when the read is issued and compared when PRDATA is sampled.
module tb_arb_grant_monitor;

`ifdef ARB_MON_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic       PCLK;
  logic       PRESETn;
  logic [7:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [3:0] STARVE;
  logic       IRQ;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  arb_grant_monitor #(.N_REQ(4), .STARVE_LIMIT_RST(8'd16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .REQ(REQ), .GNT(GNT), .STARVE(STARVE), .IRQ(IRQ)
  );

  initial PCLK = 1'b0;
  always #50 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] gnt, input int cycles);
    REQ = req;
    GNT = gnt;
    for (int c = 0; c < cycles; c++) tick();
  endtask

  task automatic apbSetup(input logic [7:0] addr, input logic [7:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    tick();
  endtask

  task automatic apbAccess();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbWrite(input logic [7:0] addr, input logic [7:0] data);
    apbSetup(addr, data);
    apbAccess();
  endtask

  task automatic expectRead(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    #1;
    PENABLE = 1'b1;
    #1;
    checkOutput(tag_q.pop_front(), {24'h0, PRDATA}, {24'h0, exp_q.pop_front()});
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; PADDR = 8'h00; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = 8'h00; REQ = 4'h0; GNT = 4'h0;
    tick();
    tick();
    PRESETn = 1'b1;

    // reset state
    expectRead(8'h00, 8'h01, "rst_ctrl");
    expectRead(8'h04, 8'h10, "rst_limit");
    expectRead(8'h08, 8'h00, "rst_status");
    for (int i = 0; i < 4; i++) expectRead(8'(8'h10 + i), 8'h00, $sformatf("rst_gnt_cnt%0d", i));
    checkOutput("rst_pready", {31'h0, PREADY}, 32'h1);
    checkOutput("rst_starve", {28'h0, STARVE}, 32'h0);
    checkOutput("rst_irq", {31'h0, IRQ}, 32'h0);

    // grant counting: held grant counts once, two regrants
    applyStimulus(4'b0010, 4'b0010, 5);
    applyStimulus(4'b0010, 4'b0000, 1);
    applyStimulus(4'b0010, 4'b0010, 1);
    applyStimulus(4'b0010, 4'b0000, 1);
    applyStimulus(4'b0010, 4'b0010, 1);
    applyStimulus(4'b0000, 4'b0000, 1);
    expectRead(8'h10, 8'h00, "cnt_gnt0");
    expectRead(8'h11, 8'h03, "cnt_gnt1");
    expectRead(8'h12, 8'h00, "cnt_gnt2");
    expectRead(8'h13, 8'h00, "cnt_gnt3");
    expectRead(8'h21, 8'h01, "cnt_max_wait1");
    expectRead(8'h08, 8'h00, "cnt_status");

    // starvation at limit 4
    apbWrite(8'h04, 8'h04);
    applyStimulus(4'b0100, 4'b0000, 3);
    expectRead(8'h08, 8'h00, "stv_status_pre");
    checkOutput("stv_pin_pre", {28'h0, STARVE}, 32'h0);
    applyStimulus(4'b0100, 4'b0000, 1);
    expectRead(8'h08, 8'h04, "stv_status_set");
    checkOutput("stv_pin_set", {28'h0, STARVE}, 32'h4);
    applyStimulus(4'b0100, 4'b0000, 2);
    expectRead(8'h22, 8'h06, "stv_max_wait2");
    apbWrite(8'h08, 8'h04);
    expectRead(8'h08, 8'h00, "stv_w1c");
    checkOutput("stv_pin_w1c", {28'h0, STARVE}, 32'h0);
    expectRead(8'h22, 8'h08, "stv_max_wait2_b");
    applyStimulus(4'b0000, 4'b0000, 1);
    applyStimulus(4'b0100, 4'b0000, 2);
    apbWrite(8'h08, 8'h04);
    expectRead(8'h08, 8'h04, "stv_set_beats_w1c");
    checkOutput("stv_pin_set_w1c", {28'h0, STARVE}, 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1);
    apbWrite(8'h08, 8'h04);
    expectRead(8'h08, 8'h00, "stv_cleared");

    // saturation with starvation detection disabled
    apbWrite(8'h04, 8'h00);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(4'b0001, 4'b0001, 1);
      applyStimulus(4'b0001, 4'b0000, 1);
    end
    applyStimulus(4'b0000, 4'b0000, 1);
    expectRead(8'h10, 8'hFF, "sat_gnt_cnt0");
    expectRead(8'h20, 8'h01, "sat_max_wait0_short");
    applyStimulus(4'b0001, 4'b0000, 300);
    applyStimulus(4'b0000, 4'b0000, 1);
    expectRead(8'h20, 8'hFF, "sat_max_wait0");
    expectRead(8'h08, 8'h00, "sat_limit0_no_starve");
    expectRead(8'h04, 8'h00, "sat_limit");

    // protocol errors and IRQ
`ifdef ARB_MON_IRQ_EN
    apbWrite(8'h0C, 8'h30);
    expectRead(8'h0C, 8'h30, "irq_mask");
`else
    apbWrite(8'h0C, 8'hFF);
    expectRead(8'h0C, 8'h00, "unmapped_0c");
`endif
    expectRead(8'h30, 8'h00, "unmapped_30");
    applyStimulus(4'b0011, 4'b0011, 1);
    expectRead(8'h08, 8'h10, "err_multi");
    checkOutput("err_irq_lag", {31'h0, IRQ}, 32'h0);
    applyStimulus(4'b0000, 4'b1000, 1);
    expectRead(8'h08, 8'h30, "err_spur");
    checkOutput("err_irq", {31'h0, IRQ}, {31'h0, IRQ_BUILD});
    expectRead(8'h13, 8'h01, "err_gnt_cnt3");
    expectRead(8'h11, 8'h04, "err_gnt_cnt1");
    applyStimulus(4'b0000, 4'b0000, 1);
    apbWrite(8'h08, 8'h30);
    expectRead(8'h08, 8'h00, "err_w1c");
    checkOutput("err_irq_hold", {31'h0, IRQ}, {31'h0, IRQ_BUILD});
    applyStimulus(4'b0000, 4'b0000, 1);
    checkOutput("err_irq_clear", {31'h0, IRQ}, 32'h0);

    // EN=0 freezes counters; re-enable with grant held gives no false edge
    apbWrite(8'h00, 8'h00);
    expectRead(8'h00, 8'h00, "en_ctrl_off");
    applyStimulus(4'b0100, 4'b0000, 10);
    applyStimulus(4'b0011, 4'b0011, 2);
    applyStimulus(4'b0010, 4'b0010, 1);
    apbWrite(8'h00, 8'h01);
    applyStimulus(4'b0010, 4'b0010, 2);
    expectRead(8'h11, 8'h04, "en_gnt_cnt1");
    expectRead(8'h10, 8'hFF, "en_gnt_cnt0");
    expectRead(8'h22, 8'h08, "en_max_wait2");
    expectRead(8'h08, 8'h00, "en_status");
    expectRead(8'h00, 8'h01, "en_ctrl_on");
    applyStimulus(4'b0000, 4'b0000, 1);

    // CLR concurrent with a grant edge
    apbSetup(8'h00, 8'h03);
    REQ = 4'b0010;
    GNT = 4'b0010;
    apbAccess();
    applyStimulus(4'b0010, 4'b0010, 1);
    applyStimulus(4'b0000, 4'b0000, 1);
    for (int i = 0; i < 4; i++) expectRead(8'(8'h10 + i), 8'h00, $sformatf("clr_gnt_cnt%0d", i));
    expectRead(8'h20, 8'h00, "clr_max_wait0");
    expectRead(8'h22, 8'h00, "clr_max_wait2");
    expectRead(8'h08, 8'h00, "clr_status");
    expectRead(8'h00, 8'h01, "clr_ctrl");

    // reset mid-traffic
    apbWrite(8'h04, 8'h04);
    applyStimulus(4'b0110, 4'b0010, 6);
    expectRead(8'h08, 8'h04, "mid_status_pre");
    checkOutput("mid_starve_pre", {28'h0, STARVE}, 32'h4);
    #10;
    PRESETn = 1'b0;
    #1;
    checkOutput("mid_starve_rst", {28'h0, STARVE}, 32'h0);
    checkOutput("mid_pready_rst", {31'h0, PREADY}, 32'h1);
    checkOutput("mid_irq_rst", {31'h0, IRQ}, 32'h0);
    expectRead(8'h00, 8'h01, "mid_ctrl");
    expectRead(8'h04, 8'h10, "mid_limit");
    expectRead(8'h08, 8'h00, "mid_status");
    expectRead(8'h11, 8'h00, "mid_gnt_cnt1");
    expectRead(8'h22, 8'h00, "mid_max_wait2");
    tick();
    PRESETn = 1'b1;
    applyStimulus(4'b0110, 4'b0010, 3);
    expectRead(8'h11, 8'h01, "post_gnt_cnt1");
    expectRead(8'h22, 8'h03, "post_max_wait2");
    expectRead(8'h08, 8'h00, "post_status");
    applyStimulus(4'b0000, 4'b0000, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arb_grant_monitor.md
Name: arb_grant_monitor

Overview:
- Passive observer downstream of the multi-mode arbiter. It consumes the effective request vector and the arbiter's GNT output.
- Measures per-requester grant counts and worst-case wait latency, detects starvation and grant-protocol violations, and exposes results through its own APB slave port.
- Sits beside the arbiter top level and shares PCLK/PRESETn. It never drives the arbiter.

Parameters:
- N_REQ, 4, number of requesters observed (register map below is defined for 4).
- STARVE_LIMIT_RST, 8'd16, reset value of the STARVE_LIMIT register.

Ports:
- PCLK  input  1  clock
- PRESETn  input  1  asynchronous active-low reset
- PADDR  input  8  APB address
- PSEL  input  1  APB select
- PENABLE  input  1  APB enable
- PWRITE  input  1  APB write
- PWDATA  input  8  APB write data
- PRDATA  output  8  APB read data
- PREADY  output  1  APB ready
- REQ  input  N_REQ  effective request vector fed to the arbiter (post-bypass mux)
- GNT  input  N_REQ  arbiter grant vector
- STARVE  output  N_REQ  sticky starvation flags (mirror of STATUS[3:0])
- IRQ  output  1  interrupt (see Optional Feature)

Behaviour:
- Reset is asynchronous on PRESETn=0. All registers and counters go to 0, except STARVE_LIMIT=STARVE_LIMIT_RST and CTRL.EN=1. Outputs are 0 except PREADY=1.
- APB:
  - PREADY is always 1, giving zero wait states.
  - A write commits on the rising edge with PSEL&PENABLE&PWRITE.
  - PRDATA is combinational from PADDR when PSEL&!PWRITE, else 8'h00.
  - Unmapped addresses read 0, and writes to them are ignored.
- Register map:
  - 0x00 CTRL RW: bit0 EN, bit1 CLR. CLR self-clears; reads as 0.
  - 0x04 STARVE_LIMIT RW 8b. A value of 0 disables starvation detection.
  - 0x08 STATUS W1C:
    - [3:0] starve sticky
    - [4] multi-grant error (popcount(GNT)>1)
    - [5] spurious grant (GNT[i]&!REQ[i])
  - 0x10+i GNT_CNT[i] RO 8b.
  - 0x20+i MAX_WAIT[i] RO 8b.
- Wait counter WAIT[i] (internal, 8b, saturating at 255):
  - If EN & REQ[i] & !GNT[i]: WAIT[i] increments.
  - Otherwise: WAIT[i] is cleared to 0.
  - MAX_WAIT[i] <= max(MAX_WAIT[i], WAIT[i]+1) on each increment cycle, also saturating at 255.
- Grant counter:
  - GNT_CNT[i] increments once per grant rising edge, i.e. GNT[i]=1 while the registered previous GNT[i]=0.
  - A grant held for multiple cycles counts once.
  - The counter saturates at 255; it never wraps.
- Starvation:
  - STATUS[i] is set on the cycle WAIT[i] transitions to value == STARVE_LIMIT, provided STARVE_LIMIT != 0.
  - It stays set until cleared by W1C or CLR.
  - STARVE[i] = STATUS[i], registered, with no extra latency beyond the set edge.
- Error flags:
  - STATUS[4] and STATUS[5] are set on any cycle with the violation while EN=1.
  - Both are sticky until W1C.
- EN=0:
  - WAIT counters are held at 0.
  - GNT_CNT, MAX_WAIT and STATUS hold their values.
  - The previous-GNT register keeps tracking GNT, so re-enabling does not create a false edge.
- CLR=1 write:
  - On the next edge, clears GNT_CNT, MAX_WAIT, WAIT and STATUS.
  - CLR wins over any simultaneous increment or set in that cycle.
- Simultaneous events:
  - W1C and a hardware set of the same STATUS bit in the same cycle: the set wins and the bit stays 1.
  - A grant edge and WAIT clearing in the same cycle are both performed.
- Reset mid-operation: all state is cleared immediately (asynchronous). The first cycle after reset treats the previous GNT as 0, so a GNT already high counts once.

Optional Feature:
- Macro: ARB_MON_IRQ_EN.
- Defined:
  - Adds 0x0C IRQ_MASK RW 6b, reset 0.
  - IRQ is registered and equals |(STATUS[5:0] & IRQ_MASK). It deasserts one cycle after the causing bits are cleared or masked.
- Undefined:
  - IRQ is tied 0.
  - 0x0C is unmapped (reads 0, writes ignored).

Test Plan:
- Reset check: assert PRESETn=0 mid-traffic -> all counters and STATUS read 0, STARVE_LIMIT reads 0x10, PREADY=1, STARVE=0.
- Grant counting: hold REQ[1]=1 with GNT=4'b0010 for 5 cycles, drop GNT, then regrant twice -> GNT_CNT[1]=3, other GNT_CNT=0.
- Starvation: set STARVE_LIMIT=4, hold REQ[2]=1 with GNT=0 -> STATUS[2] and STARVE[2] set on the 4th wait cycle, MAX_WAIT[2] keeps counting. Write 0x08=0x04 -> bit cleared. Write while still starving at WAIT==limit -> stays 1.
- Saturation: 300 grant edges on requester 0 -> GNT_CNT[0]=255. 300-cycle wait -> MAX_WAIT[0]=255.
- Protocol errors: drive GNT=4'b0011 -> STATUS[4]=1. Drive GNT=4'b1000 with REQ[3]=0 -> STATUS[5]=1. With ARB_MON_IRQ_EN and IRQ_MASK=0x30 -> IRQ=1 the next cycle.
- CLR and EN: write CTRL=0x00, pulse requests -> counters frozen. Write CTRL=0x03 concurrent with a grant edge -> all counters read 0 afterwards and CTRL reads 0x01.
